// File: rtl/dcsformer_mh_if.sv
// Handshake bundle for dcsformer_mh: token input stream, weight input stream
// and result output stream, each with its own valid/ready pair.
interface dcsformer_mh_if #(
  parameter int DW = 8,
  parameter int OW = 32
) ();

  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          i_ready;
  logic [1:0]    mode;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          o_valid;
  logic [OW-1:0] o_data;
  logic          o_last;
  logic          o_ready;

  modport master (
    output i_valid, i_data, mode, w_valid, w_data, o_ready,
    input  i_ready, w_ready, o_valid, o_data, o_last
  );

  modport slave (
    input  i_valid, i_data, mode, w_valid, w_data, o_ready,
    output i_ready, w_ready, o_valid, o_data, o_last
  );

endinterface

// File: rtl/dcsformer_mh.sv
// Multi-head sparse attention: loads token matrix X, forms S = X*X^T one MAC per
// cycle, masks each row of S against its mean and multiplies by streamed weights.
module dcsformer_mh #(
  parameter int N_TOK  = 8,
  parameter int D_DIM  = 16,
  parameter int DW     = 8,
  parameter int N_WCOL = 1,
  parameter int OW     = 32
) (
  input logic           clk,
  input logic           rst_n,
  dcsformer_mh_if.slave bus
);

  localparam int LN = $clog2(N_TOK);
  localparam int LD = (D_DIM > 1) ? $clog2(D_DIM) : 1;
  localparam int LC = (N_WCOL > 1) ? $clog2(N_WCOL) : 1;
  localparam int SW = 2 * DW + $clog2(D_DIM);
  localparam int RW = SW + LN;
  localparam int PW = SW + DW;

  typedef enum logic [2:0] {IDLE, LOAD, SCORE, WAITW, COMPUTE, OUT} state_e;

  state_e        state_q;
  logic [1:0]    mode_q;
  logic          irdy_q;
  logic          wrdy_q;
  logic          ovalid_q;
  logic          olast_q;
  logic [OW-1:0] odata_q;

  logic [N_TOK-1:0][D_DIM-1:0][DW-1:0]  xMem_q;
  logic [N_TOK-1:0][N_TOK-1:0][SW-1:0]  sMem_q;
  logic [N_TOK-1:0][SW-1:0]             meanMem_q;
  logic [N_WCOL-1:0][N_TOK-1:0][DW-1:0] wMem_q;
  logic [N_WCOL-1:0][N_TOK-1:0][OW-1:0] yMem_q;

  // tokA: row index (load/score/compute/output); tokB: column j (score/weights/compute)
  logic [LN-1:0] tokA_q;
  logic [LN-1:0] tokB_q;
  logic [LD-1:0] dim_q;
  logic [LC-1:0] col_q;

  logic [SW-1:0] sAcc_q;
  logic [RW-1:0] rowSum_q;
  logic [OW-1:0] yAcc_q;

  logic [2*DW-1:0] xProd_d;
  logic [SW-1:0]   sSum_d;
  logic [RW-1:0]   rowSum_d;
  logic [SW-1:0]   mVal_d;
  logic [PW-1:0]   yProd_d;
  logic [OW-1:0]   yAcc_d;
  logic [LN-1:0]   nextA_d;
  logic [LC-1:0]   nextC_d;
  logic            lastDim;
  logic            lastA;
  logic            lastB;
  logic            lastC;

  function automatic logic [SW-1:0] maskScore(input logic [SW-1:0] s,
                                              input logic [SW-1:0] m,
                                              input logic [1:0]    md);
    case (md)
      2'd0:    return (s >= m) ? s : '0;
      2'd2:    return (s > m) ? s : '0;
      default: return s;
    endcase
  endfunction

  always_comb begin
    lastDim  = (dim_q == LD'(D_DIM - 1));
    lastA    = (tokA_q == LN'(N_TOK - 1));
    lastB    = (tokB_q == LN'(N_TOK - 1));
    lastC    = (col_q == LC'(N_WCOL - 1));
    xProd_d  = (2*DW)'(xMem_q[tokA_q][dim_q]) * (2*DW)'(xMem_q[tokB_q][dim_q]);
    sSum_d   = sAcc_q + SW'(xProd_d);
    rowSum_d = rowSum_q + RW'(sSum_d);
    mVal_d   = maskScore(sMem_q[tokA_q][tokB_q], meanMem_q[tokA_q], mode_q);
    yProd_d  = PW'(mVal_d) * PW'(wMem_q[col_q][tokB_q]);
    yAcc_d   = yAcc_q + OW'(yProd_d);
    nextA_d  = tokA_q + LN'(1);
    nextC_d  = lastA ? (lastC ? '0 : col_q + LC'(1)) : col_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      irdy_q    <= 1'b1;
      wrdy_q    <= 1'b0;
      ovalid_q  <= 1'b0;
      olast_q   <= 1'b0;
      odata_q   <= '0;
      xMem_q    <= '0;
      sMem_q    <= '0;
      meanMem_q <= '0;
      wMem_q    <= '0;
      yMem_q    <= '0;
      tokA_q    <= '0;
      tokB_q    <= '0;
      dim_q     <= '0;
      col_q     <= '0;
      sAcc_q    <= '0;
      rowSum_q  <= '0;
      yAcc_q    <= '0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (bus.i_valid) begin
            xMem_q[tokA_q][dim_q] <= bus.i_data;
            if (state_q == IDLE) begin
              mode_q  <= bus.mode;
              state_q <= LOAD;
            end
            dim_q <= lastDim ? '0 : dim_q + LD'(1);
            if (lastDim) begin
              tokA_q <= nextA_d;
              if (lastA) begin
                state_q <= SCORE;
                irdy_q  <= 1'b0;
              end
            end
          end
        end

        SCORE: begin
          dim_q <= lastDim ? '0 : dim_q + LD'(1);
          if (lastDim) begin
            sMem_q[tokA_q][tokB_q] <= sSum_d;
            sAcc_q <= '0;
            tokB_q <= tokB_q + LN'(1);
            if (lastB) begin
              // N_TOK is a power of two, so the floor division is a shift
              meanMem_q[tokA_q] <= SW'(rowSum_d >> LN);
              rowSum_q <= '0;
              tokA_q   <= nextA_d;
              if (lastA) begin
                state_q <= WAITW;
                wrdy_q  <= 1'b1;
              end
            end else begin
              rowSum_q <= rowSum_d;
            end
          end else begin
            sAcc_q <= sSum_d;
          end
        end

        WAITW: begin
          if (bus.w_valid) begin
            wMem_q[col_q][tokB_q] <= bus.w_data;
            tokB_q <= tokB_q + LN'(1);
            if (lastB) begin
              col_q <= lastC ? '0 : col_q + LC'(1);
              if (lastC) begin
                state_q <= COMPUTE;
                wrdy_q  <= 1'b0;
              end
            end
          end
        end

        COMPUTE: begin
          tokB_q <= tokB_q + LN'(1);
          if (lastB) begin
            yMem_q[col_q][tokA_q] <= yAcc_d;
            yAcc_q <= '0;
            tokA_q <= nextA_d;
            if (lastA) begin
              col_q <= nextC_d;
              if (lastC) begin
                state_q  <= OUT;
                ovalid_q <= 1'b1;
                odata_q  <= yMem_q[0][0];
                olast_q  <= 1'b0;
              end
            end
          end else begin
            yAcc_q <= yAcc_d;
          end
        end

        OUT: begin
          if (bus.o_ready) begin
            if (olast_q) begin
              state_q  <= IDLE;
              irdy_q   <= 1'b1;
              ovalid_q <= 1'b0;
              odata_q  <= '0;
              olast_q  <= 1'b0;
              tokA_q   <= '0;
              col_q    <= '0;
            end else begin
              tokA_q  <= nextA_d;
              col_q   <= nextC_d;
              odata_q <= yMem_q[nextC_d][nextA_d];
              olast_q <= (nextC_d == LC'(N_WCOL - 1)) && (nextA_d == LN'(N_TOK - 1));
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_ready = irdy_q;
  assign bus.w_ready = wrdy_q;
  assign bus.o_valid = ovalid_q;
  assign bus.o_data  = odata_q;
  assign bus.o_last  = olast_q;

endmodule

// File: tb/tb_dcsformer_mh.sv
// Bench for dcsformer_mh: directed and randomized frames on a single-head and a
// two-head instance, compared against a plain arithmetic attention model.
module tb_dcsformer_mh;

  localparam int N_TOK = 8;
  localparam int D_DIM = 16;
  localparam int DW    = 8;
  localparam int OW    = 32;
  localparam int MAXC  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          sel     = 1'b0;
  logic          iv      = 1'b0;
  logic          wv      = 1'b0;
  logic          oRdyDrv = 1'b0;
  logic [DW-1:0] id      = '0;
  logic [DW-1:0] wd      = '0;
  logic [1:0]    iMode   = '0;
  logic          iRdy;
  logic          wRdy;
  logic          oValid;
  logic          oLast;
  logic [OW-1:0] oData;

  int checks = 0;
  int errors = 0;

  int unsigned   xRef [N_TOK][D_DIM];
  int unsigned   wRef [MAXC][N_TOK];
  logic [OW-1:0] expY [$];

  dcsformer_mh_if #(.DW(DW), .OW(OW)) bus1 ();
  dcsformer_mh_if #(.DW(DW), .OW(OW)) bus2 ();

  // Only the selected instance sees valid/ready activity; the other stays idle
  assign bus1.i_valid = iv & ~sel;
  assign bus1.i_data  = id;
  assign bus1.mode    = iMode;
  assign bus1.w_valid = wv & ~sel;
  assign bus1.w_data  = wd;
  assign bus1.o_ready = oRdyDrv & ~sel;
  assign bus2.i_valid = iv & sel;
  assign bus2.i_data  = id;
  assign bus2.mode    = iMode;
  assign bus2.w_valid = wv & sel;
  assign bus2.w_data  = wd;
  assign bus2.o_ready = oRdyDrv & sel;

  assign iRdy   = sel ? bus2.i_ready : bus1.i_ready;
  assign wRdy   = sel ? bus2.w_ready : bus1.w_ready;
  assign oValid = sel ? bus2.o_valid : bus1.o_valid;
  assign oLast  = sel ? bus2.o_last  : bus1.o_last;
  assign oData  = sel ? bus2.o_data  : bus1.o_data;

  dcsformer_mh #(.N_TOK(N_TOK), .D_DIM(D_DIM), .DW(DW), .N_WCOL(1), .OW(OW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  dcsformer_mh #(.N_TOK(N_TOK), .D_DIM(D_DIM), .DW(DW), .N_WCOL(2), .OW(OW)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  task automatic checkOutput(input string tag, input logic [OW-1:0] observed,
                             input logic [OW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void fillTokens(input int kind);
    for (int t = 0; t < N_TOK; t++)
      for (int d = 0; d < D_DIM; d++)
        case (kind)
          0:       xRef[t][d] = 1;
          1:       xRef[t][d] = (d == t) ? 2 : 0;
          2:       xRef[t][d] = 255;
          default: xRef[t][d] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
        endcase
  endfunction

  function automatic void fillWeights(input int kind);
    for (int c = 0; c < MAXC; c++)
      for (int j = 0; j < N_TOK; j++)
        case (kind)
          0:       wRef[c][j] = 1;
          1:       wRef[c][j] = j + 1;
          2:       wRef[c][j] = 255;
          3:       wRef[c][j] = c + 1;
          default: wRef[c][j] = $urandom_range(0, 255);
        endcase
  endfunction

  // Attention reference: scores, row means, mode mask, weighted sums mod 2^OW
  function automatic void buildModel(input int md, input int nCols);
    longint s [N_TOK][N_TOK];
    longint mean [N_TOK];
    longint acc;
    longint rs;
    bit     keep;
    expY.delete();
    for (int i = 0; i < N_TOK; i++) begin
      rs = 0;
      for (int j = 0; j < N_TOK; j++) begin
        s[i][j] = 0;
        for (int d = 0; d < D_DIM; d++)
          s[i][j] += longint'(xRef[i][d]) * longint'(xRef[j][d]);
        rs += s[i][j];
      end
      mean[i] = rs / N_TOK;
    end
    for (int c = 0; c < nCols; c++)
      for (int i = 0; i < N_TOK; i++) begin
        acc = 0;
        for (int j = 0; j < N_TOK; j++) begin
          if (md == 0)      keep = (s[i][j] >= mean[i]);
          else if (md == 2) keep = (s[i][j] > mean[i]);
          else              keep = 1'b1;
          if (keep) acc += s[i][j] * longint'(wRef[c][j]);
        end
        expY.push_back(OW'(acc));
      end
  endfunction

  task automatic applyStimulus(input int md, input int nCols, input bit gaps,
                               input bit preW, input bit stall);
    int            k;
    int            cyc;
    int            got;
    int            stallCnt;
    bit            rdyNow;
    bit            holding;
    bit            idleChecked;
    logic [OW-1:0] held;
    logic          heldLast;
    sel = (nCols == 2);
    buildModel(md, nCols);

    k = 0; cyc = 0; iMode = 2'(md);
    while (k < N_TOK * D_DIM && cyc < 4000) begin
      iv     = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      id     = DW'(xRef[k / D_DIM][k % D_DIM]);
      rdyNow = iRdy;
      @(posedge clk); #1;
      if (iv && rdyNow) begin
        k++;
        if (k == 1) iMode = 2'($urandom);
      end
      cyc++;
    end
    iv = 1'b0;
    checkOutput("tokens_accepted", OW'(k), OW'(N_TOK * D_DIM));

    cyc = 0;
    while (!wRdy && cyc < N_TOK * N_TOK * D_DIM + 20) begin
      wv = preW ? 1'($urandom_range(0, 1)) : 1'b0;
      wd = DW'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    wv = 1'b0;
    checkOutput("w_ready_latency", OW'(wRdy && (cyc <= N_TOK * N_TOK * D_DIM + 8)), OW'(1));

    k = 0; cyc = 0;
    while (k < N_TOK * nCols && cyc < 2000) begin
      wv     = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      wd     = DW'(wRef[k / N_TOK][k % N_TOK]);
      rdyNow = wRdy;
      @(posedge clk); #1;
      if (wv && rdyNow) k++;
      cyc++;
    end
    wv = 1'b0;
    checkOutput("weights_accepted", OW'(k), OW'(N_TOK * nCols));
    checkOutput("w_ready_drop", OW'(wRdy), OW'(0));

    got = 0; cyc = 0; stallCnt = 0; holding = 1'b0; idleChecked = 1'b0;
    held = '0; heldLast = 1'b0;
    while (got < N_TOK * nCols && cyc < 3000) begin
      if (oValid) begin
        if (holding) begin
          checkOutput("stall_data", oData, held);
          checkOutput("stall_last", OW'(oLast), OW'(heldLast));
        end
        oRdyDrv = !(stall && got == 2 && stallCnt < 5);
        if (!oRdyDrv) begin
          stallCnt++;
          held     = oData;
          heldLast = oLast;
          holding  = 1'b1;
        end else begin
          holding = 1'b0;
          checkOutput($sformatf("y%0d", got), oData, expY[got]);
          checkOutput($sformatf("o_last%0d", got), OW'(oLast), OW'(got == N_TOK * nCols - 1));
          got++;
        end
      end else begin
        if (got > 0) checkOutput("o_valid_held", OW'(oValid), OW'(1));
        if (!idleChecked) begin
          checkOutput("idle_data_zero", oData, '0);
          idleChecked = 1'b1;
        end
        oRdyDrv = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    oRdyDrv = 1'b0;
    checkOutput("outputs_count", OW'(got), OW'(N_TOK * nCols));
    checkOutput("o_valid_drop", OW'(oValid), OW'(0));
    checkOutput("o_data_zero", oData, '0);
    checkOutput("i_ready_back", OW'(iRdy), OW'(1));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2;
    checkOutput("rst_i_ready", OW'(iRdy), OW'(1));
    checkOutput("rst_w_ready", OW'(wRdy), OW'(0));
    checkOutput("rst_o_valid", OW'(oValid), OW'(0));
    checkOutput("rst_o_data", oData, '0);
    checkOutput("rst_o_last", OW'(oLast), OW'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] all ones, mode 0");
    fillTokens(0); fillWeights(0);
    applyStimulus(0, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] all ones, mode 2");
    fillTokens(0); fillWeights(0);
    applyStimulus(2, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] diagonal tokens, ramp weights, mode 0");
    fillTokens(1); fillWeights(1);
    applyStimulus(0, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] saturated inputs, mode 1");
    fillTokens(2); fillWeights(2);
    applyStimulus(1, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] two heads, all ones, mode 0");
    fillTokens(0); fillWeights(3);
    applyStimulus(0, 2, 1'b0, 1'b0, 1'b0);

    $display("[TB] random frame with gaps, early weight pulses and output stall");
    fillTokens(3); fillWeights(4);
    applyStimulus($urandom_range(0, 3), 1, 1'b1, 1'b1, 1'b1);

    $display("[TB] reset in the middle of token load");
    sel = 1'b0; iMode = 2'd0; iv = 1'b1;
    for (int n = 0; n < 40; n++) begin
      id = DW'($urandom);
      @(posedge clk); #1;
    end
    iv = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_o_valid", OW'(oValid), OW'(0));
    checkOutput("midrst_o_data", oData, '0);
    checkOutput("midrst_i_ready", OW'(iRdy), OW'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    fillTokens(3); fillWeights(4);
    applyStimulus(3, 1, 1'b1, 1'b0, 1'b0);

    $display("[TB] two heads, random, mode 2, stall");
    fillTokens(3); fillWeights(4);
    applyStimulus(2, 2, 1'b1, 1'b1, 1'b1);

    $display("[TB] two heads, random, mode 0");
    fillTokens(3); fillWeights(4);
    applyStimulus(0, 2, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
